// File: rtl/uart_sample_rx.sv
// UART receiver that packs SAMPLE_BYTES frames into one little-endian sample and
// streams samples over valid/ready, marking the last sample of each BLOCK_SIZE block.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int SAMPLE_BYTES = 2,
  parameter int BLOCK_SIZE   = 1024
) (
  input  logic                      clk_100,
  input  logic                      sb0,
  input  logic                      uart_in,
  output logic [SAMPLE_BYTES*8-1:0] sample_data,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      sample_last,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      overflow,
  output logic [2:0]                dbg_state
);

  localparam int              BLK_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [15:0]     HALF_BIT  = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0]     FULL_BIT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(SAMPLE_BYTES - 1);
  localparam logic [BLK_W-1:0] LAST_IDX = BLK_W'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t                    state;
  logic [1:0]                sync_q;
  logic                      line;
  logic                      line_d;
  logic [15:0]               bit_cnt;
  logic [2:0]                bit_idx;
  logic [DATA_BITS-1:0]      shreg;
  logic                      byte_bad;
  logic [SAMPLE_BYTES*8-1:0] pack_reg;
  logic [SAMPLE_BYTES*8-1:0] next_pack;
  logic [1:0]                pack_idx;
  logic [BLK_W-1:0]          blk_cnt;
  logic [7:0]                rx_byte;
  logic                      tick;
  logic                      exp_par;
  logic                      commit;
  logic                      complete;

  // Edge detection looks at the synchronised line; bit sampling uses it one cycle
  // later so that with CLKS_PER_BIT=1 the START check still lands in the start bit.
  assign line = sync_q[1];

  always_ff @(posedge clk_100) begin
    if (sb0) begin
      sync_q <= 2'b11;
      line_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_in};
      line_d <= sync_q[1];
    end
  end

  assign tick      = (bit_cnt == 16'd0);
  assign exp_par   = (PARITY == 1) ? ^shreg : ~^shreg;
  assign rx_byte   = 8'(shreg);
  assign commit    = (state == STOP) && tick && line_d && !byte_bad;
  assign complete  = commit && (pack_idx == LAST_BYTE);
  assign dbg_state = state;

  always_ff @(posedge clk_100) begin
    if (sb0) begin
      state      <= IDLE;
      bit_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= '0;
      byte_bad   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!line) begin
            state   <= START;
            bit_cnt <= HALF_BIT;
          end
        end
        START: begin
          if (tick) begin
            if (!line_d) begin
              state    <= DATA;
              bit_cnt  <= FULL_BIT;
              bit_idx  <= 3'd0;
              byte_bad <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {line_d, shreg[DATA_BITS-1:1]};
            bit_cnt <= FULL_BIT;
            if (bit_idx == LAST_BIT) begin
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        PAR: begin
          if (tick) begin
            if (line_d != exp_par) begin
              parity_err <= 1'b1;
              byte_bad   <= 1'b1;
            end
            bit_cnt <= FULL_BIT;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (line_d) begin
              // A start edge already visible here keeps back-to-back frames aligned.
              if (!line) begin
                state   <= START;
                bit_cnt <= HALF_BIT;
              end else begin
                state <= IDLE;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        BREAK: begin
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    next_pack = pack_reg;
    next_pack[{pack_idx, 3'b000} +: 8] = rx_byte;
  end

  // Handshake: a sample transfers on a cycle where sample_valid and sample_ready are
  // both high; valid, data and last hold steady until then, and valid never waits on ready.
  always_ff @(posedge clk_100) begin
    if (sb0) begin
      pack_reg     <= '0;
      pack_idx     <= 2'd0;
      blk_cnt      <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      sample_last  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (commit) begin
        if (complete) begin
          pack_reg <= '0;
          pack_idx <= 2'd0;
        end else begin
          pack_reg <= next_pack;
          pack_idx <= pack_idx + 2'd1;
        end
      end
      if (complete && (!sample_valid || sample_ready)) begin
        sample_data  <= next_pack;
        sample_valid <= 1'b1;
        sample_last  <= (blk_cnt == LAST_IDX);
        blk_cnt      <= blk_cnt + 1'b1;
      end else if (complete) begin
        overflow <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
        sample_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Bench for uart_sample_rx: a default instance (1 clk/bit, no parity) and an
// even-parity instance at 16 clk/bit, checked against a byte-level reference model.
module tb_uart_sample_rx;

  localparam int BLOCK = 1024;

  logic        clk = 1'b0;
  logic        sb0;
  logic        uart_a, uart_b;
  logic        ready_a, ready_b;
  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b, last_a, last_b;
  logic        fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  logic [2:0]  dbg_a, dbg_b;

  always #5 clk = ~clk;

  uart_sample_rx u_dut_a (
    .clk_100(clk), .sb0(sb0), .uart_in(uart_a),
    .sample_data(data_a), .sample_valid(valid_a), .sample_ready(ready_a),
    .sample_last(last_a), .frame_err(fe_a), .parity_err(pe_a),
    .overflow(ov_a), .dbg_state(dbg_a)
  );

  uart_sample_rx #(.CLKS_PER_BIT(16), .PARITY(1)) u_dut_b (
    .clk_100(clk), .sb0(sb0), .uart_in(uart_b),
    .sample_data(data_b), .sample_valid(valid_b), .sample_ready(ready_b),
    .sample_last(last_b), .frame_err(fe_b), .parity_err(pe_b),
    .overflow(ov_b), .dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues hold {last, data} in the order samples must be accepted.
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];
  logic [16:0] mon_e_a, mon_e_b;
  int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0, vld_cyc_a = 0, got_a = 0;
  int fe_cnt_b = 0, pe_cnt_b = 0, got_b = 0;

  // Reference model: committed bytes gather in pend_q until a sample is whole.
  logic [7:0] pend_q[$];
  int samp_idx  = 0;
  int exp_fe_a  = 0;
  int exp_ov_a  = 0;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        bad_first;
    logic [15:0] exp_data;
    int          exp_fe;
  } vec_t;
  vec_t vecs[6];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endfunction

  function automatic void model_byte_a(input logic [7:0] b, input logic stop_ok,
                                       input logic slot_free);
    logic [15:0] s;
    if (!stop_ok) begin
      exp_fe_a++;
      return;
    end
    pend_q.push_back(b);
    if (pend_q.size() == 2) begin
      s = {pend_q[1], pend_q[0]};
      pend_q.delete();
      if (slot_free) begin
        exp_q_a.push_back({((samp_idx % BLOCK) == BLOCK - 1), s});
        samp_idx++;
      end else begin
        exp_ov_a++;
      end
    end
  endfunction

  always @(negedge clk) begin
    #1;
    if (!sb0) begin
      if (fe_a) fe_cnt_a++;
      if (pe_a) pe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (valid_a) vld_cyc_a++;
      if (fe_b) fe_cnt_b++;
      if (pe_b) pe_cnt_b++;
      if (valid_a && ready_a) begin
        got_a++;
        if (exp_q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample_a: got 0x%0h with nothing expected", data_a);
        end else begin
          mon_e_a = exp_q_a.pop_front();
          check("sample_a", 32'({last_a, data_a}), 32'(mon_e_a));
        end
      end
      if (valid_b && ready_b) begin
        got_b++;
        if (exp_q_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample_b: got 0x%0h with nothing expected", data_b);
        end else begin
          mon_e_b = exp_q_b.pop_front();
          check("sample_b", 32'({last_b, data_b}), 32'(mon_e_b));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] b, input logic stop);
    uart_a = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_a = b[i];
      @(negedge clk);
    end
    uart_a = stop;
    @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b, input logic par, input logic stop);
    uart_b = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_b = b[i];
      repeat (16) @(negedge clk);
    end
    uart_b = par;
    repeat (16) @(negedge clk);
    uart_b = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q_a.size() + exp_q_b.size()), 32'd0);
  endtask

  task automatic do_reset();
    sb0    = 1'b1;
    uart_a = 1'b1;
    uart_b = 1'b1;
    repeat (3) @(negedge clk);
    sb0 = 1'b0;
    pend_q.delete();
    samp_idx = 0;
    idle(3);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_data"},  32'(data_a),  32'd0);
    check({tag, "_valid"}, 32'(valid_a), 32'd0);
    check({tag, "_last"},  32'(last_a),  32'd0);
    check({tag, "_ferr"},  32'(fe_a),    32'd0);
    check({tag, "_perr"},  32'(pe_a),    32'd0);
    check({tag, "_ovf"},   32'(ov_a),    32'd0);
    check({tag, "_state"}, 32'(dbg_a),   32'd0);
  endtask

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, vld0, ov0, got0, pe0, gap;
    logic [7:0] b;
    logic bad;

    vecs[0] = '{8'h34, 8'h12, 1'b0, 16'h1234, 0};
    vecs[1] = '{8'h01, 8'h02, 1'b1, 16'h0201, 1};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 16'h00FF, 0};
    vecs[3] = '{8'h00, 8'hFF, 1'b0, 16'hFF00, 0};
    vecs[4] = '{8'hA5, 8'h5A, 1'b1, 16'h5AA5, 1};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 16'h0180, 0};

    sb0 = 1'b1; uart_a = 1'b1; uart_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_a("rst");
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_data_b",  32'(data_b),  32'd0);
    sb0 = 1'b0;
    idle(3);

    // Table-driven frame pairs, optionally preceded by a bad-stop frame and a long low line.
    for (int v = 0; v < 6; v++) begin
      fe0  = fe_cnt_a;
      vld0 = vld_cyc_a;
      if (vecs[v].bad_first) begin
        send_a(8'hAA, 1'b0);
        repeat (20) @(negedge clk);
        uart_a = 1'b1;
        idle(4);
      end
      exp_q_a.push_back({((samp_idx % BLOCK) == BLOCK - 1), vecs[v].exp_data});
      samp_idx++;
      send_a(vecs[v].b0, 1'b1);
      send_a(vecs[v].b1, 1'b1);
      uart_a = 1'b1;
      drain("tbl_drain", 50);
      idle(3);
      check("tbl_ferr_cnt",   32'(fe_cnt_a - fe0),   32'(vecs[v].exp_fe));
      check("tbl_valid_cyc",  32'(vld_cyc_a - vld0), 32'd1);
    end

    // A full block of back-to-back frames, then two more to see the index wrap.
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      b = 8'($urandom_range(0, 255));
      model_byte_a(b, 1'b1, 1'b1);
      send_a(b, 1'b1);
    end
    uart_a = 1'b1;
    drain("blk_drain", 60);
    check("blk_count", 32'(samp_idx), 32'd1024);
    idle(5);
    model_byte_a(8'hC3, 1'b1, 1'b1);
    send_a(8'hC3, 1'b1);
    model_byte_a(8'h3C, 1'b1, 1'b1);
    send_a(8'h3C, 1'b1);
    uart_a = 1'b1;
    drain("wrap_drain", 60);

    // Consumer stalled: the second sample must be dropped with one overflow pulse.
    ov0  = ov_cnt_a;
    got0 = got_a;
    ready_a = 1'b0;
    model_byte_a(8'h11, 1'b1, 1'b1);
    send_a(8'h11, 1'b1);
    model_byte_a(8'h22, 1'b1, 1'b1);
    send_a(8'h22, 1'b1);
    model_byte_a(8'h33, 1'b1, 1'b1);
    send_a(8'h33, 1'b1);
    model_byte_a(8'h44, 1'b1, 1'b0);
    send_a(8'h44, 1'b1);
    uart_a = 1'b1;
    idle(10);
    check("ovf_pulses", 32'(ov_cnt_a - ov0), 32'(exp_ov_a));
    check("ovf_held_valid", 32'(valid_a), 32'd1);
    check("ovf_held_data",  32'(data_a),  32'h2211);
    ready_a = 1'b1;
    drain("ovf_drain", 20);
    idle(30);
    check("ovf_accepted", 32'(got_a - got0), 32'd1);
    check("ovf_valid_low", 32'(valid_a), 32'd0);

    // Reset with a held sample, one packed byte and a half-received frame.
    ready_a = 1'b0;
    send_a(8'h9A, 1'b1);
    send_a(8'hBC, 1'b1);
    uart_a = 1'b1;
    idle(5);
    check("pre_rst_valid", 32'(valid_a), 32'd1);
    check("pre_rst_data",  32'(data_a),  32'hBC9A);
    send_a(8'h11, 1'b1);
    uart_a = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_a = 1'(i & 1);
      @(negedge clk);
    end
    sb0 = 1'b1;
    uart_a = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_a("mid_rst");
    sb0 = 1'b0;
    pend_q.delete();
    samp_idx = 0;
    ready_a = 1'b1;
    idle(3);
    model_byte_a(8'h56, 1'b1, 1'b1);
    send_a(8'h56, 1'b1);
    model_byte_a(8'h78, 1'b1, 1'b1);
    send_a(8'h78, 1'b1);
    uart_a = 1'b1;
    drain("post_rst_drain", 50);

    // Random bytes, gaps and bad stops until the block index has wrapped once more.
    fe0 = fe_cnt_a;
    exp_fe_a = 0;
    while (samp_idx < BLOCK + 2) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 15) == 0);
      model_byte_a(b, !bad, 1'b1);
      send_a(b, !bad);
      if (bad) begin
        uart_a = 1'b1;
        idle(3 + $urandom_range(0, 2));
      end else begin
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          uart_a = 1'b1;
          idle(gap);
        end
      end
    end
    uart_a = 1'b1;
    drain("rand_drain", 60);
    idle(5);
    check("rand_ferr_cnt", 32'(fe_cnt_a - fe0), 32'(exp_fe_a));

    // Even parity at 16 clocks per bit: a bad parity byte must not advance the packer.
    pe0 = pe_cnt_b;
    fe0 = fe_cnt_b;
    send_b(8'h07, 1'b0, 1'b1);
    uart_b = 1'b1;
    idle(20);
    check("par_err_pulse", 32'(pe_cnt_b - pe0), 32'd1);
    check("par_no_sample", 32'(got_b), 32'd0);
    exp_q_b.push_back({1'b0, 16'h0007});
    send_b(8'h07, 1'b1, 1'b1);
    send_b(8'h00, 1'b0, 1'b1);
    uart_b = 1'b1;
    drain("par_drain", 100);
    exp_q_b.push_back({1'b0, 16'h01A5});
    send_b(8'hA5, 1'b0, 1'b1);
    send_b(8'h01, 1'b1, 1'b1);
    uart_b = 1'b1;
    drain("par_drain2", 100);
    idle(5);
    check("par_err_total", 32'(pe_cnt_b - pe0), 32'd1);
    check("par_ferr_none", 32'(fe_cnt_b - fe0), 32'd0);
    check("a_no_parity_err", 32'(pe_cnt_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
